u_bam_seq_mult: RTL and testbench

U_BAM_SEQ_MULT -- requirements
Module: u_bam_seq_mult

---
 rtl/u_bam_seq_mult.sv | 120 ++++++++++++
 tb/tb_u_bam_seq_mult.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/u_bam_seq_mult.sv
// Sequential shift-add broken-array multiplier: one partial-product row per cycle, cut by H_CUT/V_CUT.
// Optional BAM_EXACT_MODE_EN lets a captured exact_i bypass both cuts for that operation.
module u_bam_seq_mult #(
  parameter int N     = 8,
  parameter int H_CUT = 0,
  parameter int V_CUT = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           exact_i,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*N-1:0] p_o,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [2*N-1:0]   p_q;
  logic [2*N-1:0]   p_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [N-1:0]     colmask;
  logic             row_en;
  logic [2*N-1:0]   row_term;

`ifdef BAM_EXACT_MODE_EN
  logic             exact_q;
`else
  logic             unused_exact;
  assign unused_exact = exact_i;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p_o       = p_q;

  // Row j = cnt_q keeps only columns i+j >= V_CUT, and only if j >= H_CUT.
  always_comb begin
    colmask = '0;
    for (int i = 0; i < N; i++) begin
      colmask[i] = ((i + int'(cnt_q)) >= V_CUT);
    end
    row_en = b_q[cnt_q] && (int'(cnt_q) >= H_CUT);
`ifdef BAM_EXACT_MODE_EN
    if (exact_q) begin
      colmask = '1;
      row_en  = b_q[cnt_q];
    end
`endif
    row_term = {{N{1'b0}}, (a_q & colmask)} << cnt_q;
    p_d      = row_en ? (p_q + row_term) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BAM_EXACT_MODE_EN
      exact_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            p_q        <= '0;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
`ifdef BAM_EXACT_MODE_EN
            exact_q    <= exact_i;
`endif
          end
        end
        BUSY: begin
          p_q <= p_d;
          if (cnt_q == CW'(N - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_u_bam_seq_mult.sv
// Scoreboard bench for u_bam_seq_mult: four parameter sets, directed cases then randomized traffic.
// Expected products come from a bit-sum reference model; BAM_EXACT_MODE_EN selects exact-mode expectations.
module tb_u_bam_seq_mult;

  localparam int NS[4] = '{8, 8, 16, 4};
  localparam int HS[4] = '{0, 2, 3, 0};
  localparam int VS[4] = '{10, 0, 12, 0};
  localparam int NOPS  = 1200;

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s [4];
  logic [31:0] a_s   [4];
  logic [31:0] b_s   [4];
  logic        ex_s  [4];
  logic        iv_s  [4];
  logic        or_s  [4];
  logic        ir_s  [4];
  logic        ov_s  [4];
  logic [63:0] p_s   [4];
  bit          fin   [4];
  bit          go = 1'b0;

  exp_t exp_q[4][$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, g, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] ref_p(input int n, input int h, input int v,
                                        input logic [31:0] a, input logic [31:0] b, input logic ex);
    logic [63:0] s = 64'd0;
    logic        ex_eff;
`ifdef BAM_EXACT_MODE_EN
    ex_eff = ex;
`else
    ex_eff = ex & 1'b0;
`endif
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        if (a[i] && b[j] && (ex_eff || (j >= h && i + j >= v)))
          s += 64'd1 << (i + j);
    if (n < 32) s &= (64'd1 << (2 * n)) - 64'd1;
    return s;
  endfunction

  function automatic logic [31:0] rand_op(input int n);
    logic [31:0] m;
    logic [31:0] r;
    m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    case ($urandom % 8)
      0:       r = 32'd0;
      1:       r = 32'hFFFF_FFFF;
      default: r = $urandom;
    endcase
    return r & m;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int N = NS[g];
    logic [2*N-1:0] p_w;
    logic           ir_w;
    logic           ov_w;

    u_bam_seq_mult #(.N(N), .H_CUT(HS[g]), .V_CUT(VS[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_s[g]),
      .a         (a_s[g][N-1:0]),
      .b         (b_s[g][N-1:0]),
      .exact_i   (ex_s[g]),
      .in_valid  (iv_s[g]),
      .in_ready  (ir_w),
      .p_o       (p_w),
      .out_valid (ov_w),
      .out_ready (or_s[g])
    );

    assign p_s[g]  = 64'(p_w);
    assign ir_s[g] = ir_w;
    assign ov_s[g] = ov_w;

    // Monitor: score the first DONE cycle, then require p_o to hold while out_valid stays high.
    initial begin
      bit          seen;
      logic [63:0] held;
      exp_t        e;
      seen = 1'b0;
      held = 64'd0;
      forever begin
        @(negedge clk);
        if (!rst_s[g]) begin
          seen = 1'b0;
        end else if (ov_s[g] && !seen) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result inst=%0d got=%h want=none", g, p_s[g]);
          end else begin
            e = exp_q[g].pop_front();
            chk("result", g, p_s[g], e.p);
            chk("latency", g, 64'(cyc), 64'(e.cyc + N));
          end
          held = p_s[g];
          seen = 1'b1;
        end else if (ov_s[g]) begin
          chk("hold_stable", g, p_s[g], held);
        end else begin
          seen = 1'b0;
        end
      end
    end

    initial begin
      int          ops;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rx;
      fin[g] = 1'b0;
      wait (go);
      ops = 0;
      while (ops < NOPS) begin
        @(negedge clk);
        or_s[g] = ($urandom % 4) != 0;
        if (ir_s[g]) begin
          if (($urandom % 4) != 0) begin
            ra = rand_op(N);
            rb = rand_op(N);
            rx = 1'($urandom % 2);
            a_s[g] = ra; b_s[g] = rb; ex_s[g] = rx; iv_s[g] = 1'b1;
            exp_q[g].push_back('{ref_p(N, HS[g], VS[g], ra, rb, rx), cyc + 1});
            ops++;
          end else begin
            iv_s[g] = 1'b0;
          end
        end else begin
          iv_s[g] = 1'($urandom % 2);
          a_s[g]  = $urandom;
          b_s[g]  = $urandom;
          ex_s[g] = 1'($urandom % 2);
        end
      end
      @(negedge clk);
      iv_s[g] = 1'b0;
      or_s[g] = 1'b1;
      fin[g]  = 1'b1;
    end
  end

  task automatic offer(input int g, input logic [31:0] a, input logic [31:0] b,
                       input logic ex, input logic [63:0] expp);
    int k = 0;
    while (!ir_s[g] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ir_s[g]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d got=in_ready0 want=in_ready1", g);
      return;
    end
    a_s[g] = a; b_s[g] = b; ex_s[g] = ex; iv_s[g] = 1'b1;
    exp_q[g].push_back('{expp, cyc + 1});
    @(negedge clk);
    iv_s[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int k = 0;
    while (!ir_s[g] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ir_s[g]) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst=%0d got=busy want=idle", g);
    end
  endtask

  initial begin
    int k;
    bit all_fin;
    for (int g = 0; g < 4; g++) begin
      rst_s[g] = 1'b0; a_s[g] = '0; b_s[g] = '0;
      ex_s[g] = 1'b0; iv_s[g] = 1'b0; or_s[g] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("rst_in_ready", g, 64'(ir_s[g]), 64'd1);
      chk("rst_out_valid", g, 64'(ov_s[g]), 64'd0);
      chk("rst_p", g, p_s[g], 64'd0);
    end
    for (int g = 0; g < 4; g++) rst_s[g] = 1'b1;

    offer(0, 32'hFF, 32'hFF, 1'b0, 64'hE400); wait_idle(0);
    offer(0, 32'h10, 32'h40, 1'b0, 64'h0400); wait_idle(0);
    offer(0, 32'h80, 32'h04, 1'b0, 64'h0000); wait_idle(0);
`ifdef BAM_EXACT_MODE_EN
    offer(0, 32'h80, 32'h04, 1'b1, 64'h0200); wait_idle(0);
`else
    offer(0, 32'h80, 32'h04, 1'b1, 64'h0000); wait_idle(0);
`endif
    offer(1, 32'hFF, 32'h03, 1'b0, 64'h0000); wait_idle(1);
    offer(1, 32'hFF, 32'h04, 1'b0, 64'h03FC); wait_idle(1);

    or_s[0] = 1'b0;
    offer(0, 32'hFF, 32'hFF, 1'b0, 64'hE400);
    k = 0;
    while (!ov_s[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid", 0, 64'(ov_s[0]), 64'd1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_p", 0, p_s[0], 64'hE400);
      chk("bp_in_ready", 0, 64'(ir_s[0]), 64'd0);
      iv_s[0] = 1'(c % 2 == 0);
      a_s[0] = 32'h11; b_s[0] = 32'h22;
      @(negedge clk);
    end
    iv_s[0] = 1'b0;
    or_s[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 0, 64'(ir_s[0]), 64'd1);
    chk("bp_release_valid", 0, 64'(ov_s[0]), 64'd0);
    chk("bp_release_p", 0, p_s[0], 64'hE400);

    offer(0, 32'h5A, 32'h3C, 1'b0, ref_p(8, 0, 10, 32'h5A, 32'h3C, 1'b0));
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0;
    #1;
    chk("midrst_out_valid", 0, 64'(ov_s[0]), 64'd0);
    chk("midrst_p", 0, p_s[0], 64'd0);
    chk("midrst_in_ready", 0, 64'(ir_s[0]), 64'd1);
    exp_q[0].delete();
    @(negedge clk);
    rst_s[0] = 1'b1;
    offer(0, 32'hC3, 32'h7E, 1'b0, ref_p(8, 0, 10, 32'hC3, 32'h7E, 1'b0));
    wait_idle(0);

    go = 1'b1;
    k = 0;
    all_fin = 1'b0;
    while (!all_fin && k < 80000) begin
      @(negedge clk);
      k++;
      all_fin = fin[0] && fin[1] && fin[2] && fin[3];
    end
    if (!all_fin) begin
      checks++;
      errors++;
      $display("FAIL random_timeout got=unfinished want=finished");
    end
    repeat (40) @(negedge clk);
    for (int g = 0; g < 4; g++) chk("queue_drained", g, 64'(exp_q[g].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
